// File: rtl/sram_output_pkg.sv
// Shared constants and types for the output-SRAM arbiter and its response FIFO.
package sram_output_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 10;
  localparam int STATS_W    = 32;

  typedef enum logic {
    SIDE_WR = 1'b0,
    SIDE_RD = 1'b1
  } side_e;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + STATS_W'(1) : v;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Circular read-response FIFO; pointers wrap at DEPTH so non-power-of-two depths work.
module sram_rsp_fifo #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_pop_data,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the count guards every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/sram_output_arbiter.sv
// Round-robin write/read arbiter for a single-port output SRAM with credit-based read responses.
// Optional counters (wr_cnt, rd_cnt, stall_cnt, stats_clr) are built when SRAM_ARB_STATS_EN is defined.
module sram_output_arbiter
  import sram_output_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int ADDR_W    = DEF_ADDR_W,
  parameter  int RSP_DEPTH = 4,
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sram_cen_n,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out,
  output logic              busy
`ifdef SRAM_ARB_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [STATS_W-1:0] wr_cnt,
  output logic [STATS_W-1:0] rd_cnt,
  output logic [STATS_W-1:0] stall_cnt
`endif
);

  side_e             r_last_side;
  logic              r_inflight;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_credit;
  logic              w_rd_elig;
  logic              w_gnt_wr;
  logic              w_gnt_rd;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;

  // A read may only issue if the FIFO has room for it plus any read still in flight.
  assign w_credit  = (int'(w_count) + int'(r_inflight)) < RSP_DEPTH;
  assign w_rd_elig = rd_valid && w_credit;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_gnt_wr = 1'b0;
    w_gnt_rd = 1'b0;
    if (wr_valid && w_rd_elig) begin
      if (r_last_side == SIDE_WR) w_gnt_rd = 1'b1;
      else                        w_gnt_wr = 1'b1;
    end else begin
      w_gnt_wr = wr_valid;
      w_gnt_rd = w_rd_elig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_side <= SIDE_RD;
      r_inflight  <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_inflight <= w_gnt_rd;
      if (w_gnt_wr) begin
        r_last_side <= SIDE_WR;
        r_wen       <= 1'b1;
        r_addr      <= wr_addr;
        r_wdata     <= wr_data;
      end else if (w_gnt_rd) begin
        r_last_side <= SIDE_RD;
        r_wen       <= 1'b0;
        r_addr      <= rd_addr;
      end
    end
  end

  assign wr_ready     = w_gnt_wr;
  assign rd_ready     = w_gnt_rd;
  assign sram_cen_n   = !(w_gnt_wr || w_gnt_rd);
  assign sram_wen     = w_gnt_wr ? 1'b1 : (w_gnt_rd ? 1'b0 : r_wen);
  assign sram_addr    = w_gnt_wr ? wr_addr : (w_gnt_rd ? rd_addr : r_addr);
  assign sram_data_in = w_gnt_wr ? wr_data : r_wdata;

  assign rsp_valid = (w_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign busy      = r_inflight || (w_count != '0);

  sram_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (sram_data_out),
    .i_pop       (w_pop),
    .o_pop_data  (rsp_data),
    .o_count     (w_count)
  );

`ifdef SRAM_ARB_STATS_EN
  logic [STATS_W-1:0] r_wr_cnt;
  logic [STATS_W-1:0] r_rd_cnt;
  logic [STATS_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_stall_cnt <= '0;
    end else if (stats_clr) begin
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_wr_cnt    <= sat_inc(r_wr_cnt, w_gnt_wr);
      r_rd_cnt    <= sat_inc(r_rd_cnt, w_gnt_rd);
      r_stall_cnt <= sat_inc(r_stall_cnt, rd_valid && !w_credit);
    end
  end

  assign wr_cnt    = r_wr_cnt;
  assign rd_cnt    = r_rd_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_sram_output_arbiter.sv
// Directed self-checking bench for sram_output_arbiter (RSP_DEPTH 4, plus depth-2/3 throughput instances).
module tb_sram_output_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [9:0]  wr_addr, rd_addr, sram_addr;
  logic [63:0] wr_data, rsp_data, sram_data_in, sram_data_out;
  logic        rsp_valid, rsp_ready, sram_cen_n, sram_wen, busy;

  logic        rd_valid_t;
  logic        rd_ready2, rd_ready3;
  logic        d2_wr_ready, d2_rsp_valid, d2_cen_n, d2_wen, d2_busy;
  logic        d3_wr_ready, d3_rsp_valid, d3_cen_n, d3_wen, d3_busy;
  logic [9:0]  d2_addr, d3_addr;
  logic [63:0] d2_rsp_data, d2_din, d3_rsp_data, d3_din;

`ifdef SRAM_ARB_STATS_EN
  logic        stats_clr;
  logic [31:0] wr_cnt, rd_cnt, stall_cnt;
  logic [31:0] d2_wc, d2_rc, d2_sc, d3_wc, d3_rc, d3_sc;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mem [1024];

  localparam logic [10:0] BP_RDY = 11'b110_0000_1111;
  localparam logic [2:0]  TP2_RDY = 3'b011;

  always #5 clk = ~clk;

  sram_output_arbiter #(.DATA_W(64), .ADDR_W(10), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sram_cen_n(sram_cen_n), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out), .busy(busy)
`ifdef SRAM_ARB_STATS_EN
    , .stats_clr(stats_clr), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .stall_cnt(stall_cnt)
`endif
  );

  sram_output_arbiter #(.DATA_W(64), .ADDR_W(10), .RSP_DEPTH(2)) dut_d2 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(1'b0), .wr_ready(d2_wr_ready), .wr_addr(10'd0), .wr_data(64'd0),
    .rd_valid(rd_valid_t), .rd_ready(rd_ready2), .rd_addr(10'd1),
    .rsp_valid(d2_rsp_valid), .rsp_ready(1'b1), .rsp_data(d2_rsp_data),
    .sram_cen_n(d2_cen_n), .sram_wen(d2_wen), .sram_addr(d2_addr),
    .sram_data_in(d2_din), .sram_data_out(64'd0), .busy(d2_busy)
`ifdef SRAM_ARB_STATS_EN
    , .stats_clr(1'b0), .wr_cnt(d2_wc), .rd_cnt(d2_rc), .stall_cnt(d2_sc)
`endif
  );

  sram_output_arbiter #(.DATA_W(64), .ADDR_W(10), .RSP_DEPTH(3)) dut_d3 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(1'b0), .wr_ready(d3_wr_ready), .wr_addr(10'd0), .wr_data(64'd0),
    .rd_valid(rd_valid_t), .rd_ready(rd_ready3), .rd_addr(10'd2),
    .rsp_valid(d3_rsp_valid), .rsp_ready(1'b1), .rsp_data(d3_rsp_data),
    .sram_cen_n(d3_cen_n), .sram_wen(d3_wen), .sram_addr(d3_addr),
    .sram_data_in(d3_din), .sram_data_out(64'd0), .busy(d3_busy)
`ifdef SRAM_ARB_STATS_EN
    , .stats_clr(1'b0), .wr_cnt(d3_wc), .rd_cnt(d3_rc), .stall_cnt(d3_sc)
`endif
  );

  // Behavioural single-port SRAM with one-cycle registered read data.
  always @(posedge clk) begin
    if (!sram_cen_n) begin
      if (sram_wen) mem[sram_addr] <= sram_data_in;
      else          sram_data_out  <= mem[sram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response scoreboard: every consumed response must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_extra", 64'd1, 64'd0);
      else                   check("rsp_data", rsp_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [63:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    check("wr_accept", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i * 32'h0101_0011);
  endfunction

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rd_valid_t = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; rsp_ready = 1'b1;
`ifdef SRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cen_n", sram_cen_n, 1'b1);
    check("rst_wen", sram_wen, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_ready", rd_ready, 1'b0);
    rst_n = 1'b1;
    tick();

    // Reset while a read is in flight: the read must vanish.
    rd_valid = 1'b1; rd_addr = 10'h005;
    @(negedge clk);
    check("mr_rd_ready", rd_ready, 1'b1);
    tick();
    rd_valid = 1'b0;
    check("mr_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_busy_rst", busy, 1'b0);
    check("mr_cen_n_rst", sram_cen_n, 1'b1);
    check("mr_wen_rst", sram_wen, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mr_rsp_valid", rsp_valid, 1'b0);
      check("mr_busy", busy, 1'b0);
    end
    tick();

    // Write then read of the top address.
    wr_valid = 1'b1; wr_addr = 10'h3FF; wr_data = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    check("wt_wr_ready", wr_ready, 1'b1);
    check("wt_cen_n", sram_cen_n, 1'b0);
    check("wt_wen", sram_wen, 1'b1);
    check("wt_addr", sram_addr, 10'h3FF);
    check("wt_din", sram_data_in, 64'hDEADBEEF_CAFEF00D);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'h3FF;
    @(negedge clk);
    check("rt_rd_ready", rd_ready, 1'b1);
    check("rt_cen_n", sram_cen_n, 1'b0);
    check("rt_wen", sram_wen, 1'b0);
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    check("rt_rsp_n1", rsp_valid, 1'b0);
    check("rt_busy_n1", busy, 1'b1);
    check("idle_cen_n", sram_cen_n, 1'b1);
    check("idle_wen_hold", sram_wen, 1'b0);
    check("idle_addr_hold", sram_addr, 10'h3FF);
    check("idle_din_hold", sram_data_in, 64'hDEADBEEF_CAFEF00D);
    tick();
    @(negedge clk);
    check("rt_rsp_n2", rsp_valid, 1'b1);
    tick();
    wait_drain("rt_drain");

    // Contention: both sides request every cycle; last grant was a read, so write goes first.
    begin
      int wi = 0, ri = 0;
      for (int c = 0; c < 8; c++) begin
        wr_valid = 1'b1; wr_addr = 10'(10'h020 + wi); wr_data = pat(wi);
        rd_valid = 1'b1; rd_addr = 10'(10'h020 + ri);
        @(negedge clk);
        check("ct_wr_ready", wr_ready, (c % 2) == 0);
        check("ct_rd_ready", rd_ready, (c % 2) == 1);
        if ((c % 2) == 0) wi++;
        else begin
          exp_q.push_back(pat(ri));
          ri++;
        end
        tick();
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
    end
    wait_drain("ct_drain");

    // Backpressure: preload six words; the stats clear coincides with the last write.
    for (int k = 0; k < 6; k++) begin
`ifdef SRAM_ARB_STATS_EN
      stats_clr = (k == 5);
`endif
      do_write(10'(10'h040 + k), pat(100 + k));
    end
`ifdef SRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    rsp_ready = 1'b0;
    begin
      int k = 0;
      for (int c = 0; c < 11; c++) begin
        rd_valid = 1'b1; rd_addr = 10'(10'h040 + k); rsp_ready = (c >= 8);
        @(negedge clk);
        check("bp_rd_ready", rd_ready, BP_RDY[c]);
        if (BP_RDY[c]) begin
          exp_q.push_back(pat(100 + k));
          k++;
        end
        tick();
      end
      rd_valid = 1'b0;
    end
    wait_drain("bp_drain");
`ifdef SRAM_ARB_STATS_EN
    check("st_rd_cnt", rd_cnt, 32'd6);
    check("st_wr_cnt", wr_cnt, 32'd0);
    check("st_stall_cnt", stall_cnt, 32'd5);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    @(negedge clk);
    check("st_clr_rd", rd_cnt, 32'd0);
    check("st_clr_wr", wr_cnt, 32'd0);
    check("st_clr_stall", stall_cnt, 32'd0);
    tick();
`endif

    // Throughput: depth 2 gives two grants per three cycles, depth 3 one per cycle.
    begin
      int g2 = 0, g3 = 0;
      rd_valid_t = 1'b1;
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        check("tp_d2_ready", rd_ready2, TP2_RDY[c % 3]);
        check("tp_d3_ready", rd_ready3, 1'b1);
        g2 += int'(rd_ready2);
        g3 += int'(rd_ready3);
        tick();
      end
      rd_valid_t = 1'b0;
      check("tp_d2_total", 64'(g2), 64'd6);
      check("tp_d3_total", 64'(g3), 64'd9);
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
